// File: rtl/scgra_pkg.sv
// Shared SCGRA definitions: multiply-add pipeline depth, the result tag record
// and a constant log2 helper used to size requester IDs.
package scgra_pkg;

    localparam int MULADD_LAT = 2;
    localparam int TAG_IDW    = 4;

    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } tag_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/muladd_arbiter_if.sv
// Request/result bundle between the PE issue logic (master) and the shared
// multiply-add arbiter (slave).
interface muladd_arbiter_if #(
    parameter int DWIDTH = 32,
    parameter int NREQ   = 4,
    parameter int IDW    = scgra_pkg::clog2(NREQ)
);

    // A request from requester i is accepted in any cycle where req_valid[i]
    // and req_ready[i] are both 1; the requester holds valid and operands
    // until then. Results carry no back-pressure: res_valid is a one-cycle
    // strobe that the consumer must take.
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*DWIDTH-1:0] req_a;
    logic [NREQ*DWIDTH-1:0] req_b;
    logic [NREQ*DWIDTH-1:0] req_c;
    logic [NREQ-1:0]        req_sub;
    logic                   res_valid;
    logic [IDW-1:0]         res_id;
    logic [DWIDTH-1:0]      res_p;

    modport master (
        output req_valid, req_a, req_b, req_c, req_sub,
        input  req_ready, res_valid, res_id, res_p
    );

    modport slave (
        input  req_valid, req_a, req_b, req_c, req_sub,
        output req_ready, res_valid, res_id, res_p
    );

endinterface

// File: rtl/Mul_Add.sv
// Two-stage multiply-accumulate: p = a*b +/- c, all modulo 2^DWIDTH.
// The low DWIDTH bits of a signed product equal those of the unsigned one.
module Mul_Add #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              Resetn,
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    input  logic [DWIDTH-1:0] c,
    input  logic              subtract,
    output logic [DWIDTH-1:0] p
);

    logic [DWIDTH-1:0] prod_q;
    logic [DWIDTH-1:0] c_q;
    logic              sub_q;
    logic [DWIDTH-1:0] p_q;

    always_ff @(posedge clk) begin
        if (!Resetn) begin
            prod_q <= '0;
            c_q    <= '0;
            sub_q  <= 1'b0;
            p_q    <= '0;
        end else begin
            prod_q <= a * b;
            c_q    <= c;
            sub_q  <= subtract;
            p_q    <= sub_q ? (prod_q - c_q) : (prod_q + c_q);
        end
    end

    assign p = p_q;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin priority encoder: grants the first requester found searching
// from ptr_i upward, modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    logic           found;
    logic [IDW-1:0] idx;
    int             j;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr_i) + k) % NREQ;
            if (!found && req_i[j]) begin
                found = 1'b1;
                idx   = IDW'(j);
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        if (found) gnt_o[idx] = 1'b1;
    end

    assign idx_o = idx;
    assign any_o = found;

endmodule

// File: rtl/muladd_arbiter.sv
// Shares one Mul_Add among NREQ requesters with round-robin grants and returns
// each result tagged with its requester ID after the fixed pipeline latency.
module muladd_arbiter
    import scgra_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int NREQ   = 4,
    parameter int IDW    = clog2(NREQ)
) (
    input  logic               clk,
    input  logic               Resetn,
    input  logic               hold,
    muladd_arbiter_if.slave    bus,
    output logic [31:0]        issue_cnt
);

    logic [NREQ-1:0]   req_eligible;
    logic [NREQ-1:0]   gnt;
    logic [IDW-1:0]    gnt_idx;
    logic              gnt_any;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [31:0]       issue_cnt_q, issue_cnt_d;
    tag_t              tag_q [MULADD_LAT];
    tag_t              tag_d;
    logic [DWIDTH-1:0] op_a, op_b, op_c;
    logic              op_sub;
    logic [DWIDTH-1:0] mul_p;
    logic              unused_tag_bits;

    // Masking the request vector keeps req_ready at zero during reset or hold.
    assign req_eligible = (Resetn && !hold) ? bus.req_valid : '0;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req_i (req_eligible),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    assign bus.req_ready = gnt;

    always_comb begin
        op_a   = '0;
        op_b   = '0;
        op_c   = '0;
        op_sub = 1'b0;
        if (gnt_any) begin
            op_a   = bus.req_a[int'(gnt_idx)*DWIDTH +: DWIDTH];
            op_b   = bus.req_b[int'(gnt_idx)*DWIDTH +: DWIDTH];
            op_c   = bus.req_c[int'(gnt_idx)*DWIDTH +: DWIDTH];
            op_sub = bus.req_sub[gnt_idx];
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        issue_cnt_d = issue_cnt_q;
        tag_d       = '0;
        if (gnt_any) begin
            rr_ptr_d    = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
            issue_cnt_d = issue_cnt_q + 32'd1;
            tag_d.valid = 1'b1;
            tag_d.id    = TAG_IDW'(gnt_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (!Resetn) begin
            rr_ptr_q    <= '0;
            issue_cnt_q <= '0;
            for (int s = 0; s < MULADD_LAT; s++) tag_q[s] <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            issue_cnt_q <= issue_cnt_d;
            tag_q[0]    <= tag_d;
            for (int s = 1; s < MULADD_LAT; s++) tag_q[s] <= tag_q[s-1];
        end
    end

    Mul_Add #(.DWIDTH(DWIDTH)) u_mul_add (
        .clk      (clk),
        .Resetn   (Resetn),
        .a        (op_a),
        .b        (op_b),
        .c        (op_c),
        .subtract (op_sub),
        .p        (mul_p)
    );

    // Gating with Resetn suppresses a result that would land in the reset cycle.
    assign bus.res_valid = tag_q[MULADD_LAT-1].valid & Resetn;
    assign bus.res_id    = tag_q[MULADD_LAT-1].id[IDW-1:0];
    assign bus.res_p     = mul_p;
    assign issue_cnt     = issue_cnt_q;
    assign unused_tag_bits = ^tag_q[MULADD_LAT-1].id;

endmodule

// File: tb/tb_muladd_arbiter.sv
// Randomized bench for muladd_arbiter against a queue-based model of grants,
// results-by-due-cycle and the issue count.
module tb_muladd_arbiter;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int IW = 2;

    typedef struct {
        int          due;
        int          id;
        logic [W-1:0] p;
    } res_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        hold_r = 1'b0;
    logic [31:0] issue_cnt;

    muladd_arbiter_if #(.DWIDTH(W), .NREQ(N), .IDW(IW)) bus ();

    muladd_arbiter #(.DWIDTH(W), .NREQ(N), .IDW(IW)) dut (
        .clk       (clk),
        .Resetn    (rstn),
        .hold      (hold_r),
        .bus       (bus),
        .issue_cnt (issue_cnt)
    );

    always #5 clk = ~clk;

    logic [N-1:0] vld;
    logic [N-1:0] sub_v;
    logic [W-1:0] a_v [N];
    logic [W-1:0] b_v [N];
    logic [W-1:0] c_v [N];

    res_t        exp_q [$];
    int          m_ptr;
    logic [31:0] m_cnt;
    int          cyc;
    int          pend_g;
    int          n_checks;
    int          n_err;

    logic [N-1:0]  er;
    logic          ev;
    logic [IW-1:0] eid;
    logic [W-1:0]  ep;
    logic [31:0]   ec;

    function automatic logic [W-1:0] madd(logic [W-1:0] a, logic [W-1:0] b,
                                          logic [W-1:0] c, logic s);
        logic [W-1:0] prod;
        prod = a * b;
        return s ? prod - c : prod + c;
    endfunction

    task automatic rand_ops(input int i);
        a_v[i]   = $urandom;
        b_v[i]   = $urandom;
        c_v[i]   = $urandom;
        sub_v[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic apply();
        bus.req_valid = vld;
        bus.req_sub   = sub_v;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*W +: W] = a_v[i];
            bus.req_b[i*W +: W] = b_v[i];
            bus.req_c[i*W +: W] = c_v[i];
        end
    endtask

    // Expected outputs for the current cycle from the model state.
    task automatic eval_cycle();
        int g;
        g  = -1;
        er = '0;
        if (rstn && !hold_r) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && vld[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        pend_g = g;
        ev  = 1'b0;
        eid = '0;
        ep  = '0;
        if (rstn && exp_q.size() > 0 && exp_q[0].due == cyc) begin
            ev  = 1'b1;
            eid = IW'(exp_q[0].id);
            ep  = exp_q[0].p;
        end
        ec = m_cnt;
    endtask

    // Commit the model at the clock edge, then move to the next cycle.
    task automatic advance();
        res_t r;
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) void'(exp_q.pop_front());
        if (!rstn) begin
            exp_q.delete();
            m_ptr = 0;
            m_cnt = '0;
        end else if (pend_g >= 0) begin
            r.due = cyc + 2;
            r.id  = pend_g;
            r.p   = madd(a_v[pend_g], b_v[pend_g], c_v[pend_g], sub_v[pend_g]);
            exp_q.push_back(r);
            m_ptr = (pend_g + 1) % N;
            m_cnt = m_cnt + 32'd1;
            vld[pend_g] = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vld = 4'($urandom);
            for (int j = 0; j < N; j++) rand_ops(j);
            apply();
            @(negedge clk);
            eval_cycle();
            n_checks++;
            if (bus.req_ready !== er) begin
                n_err++; $display("FAIL reset_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, er);
            end
            n_checks++;
            if (bus.res_valid !== 1'b0 || bus.res_id !== '0 || bus.res_p !== '0) begin
                n_err++; $display("FAIL reset_outputs cyc=%0d got v=%b id=%0d p=%h exp v=0 id=0 p=0", cyc, bus.res_valid, bus.res_id, bus.res_p);
            end
            n_checks++;
            if (issue_cnt !== 32'd0) begin
                n_err++; $display("FAIL reset_cnt cyc=%0d got=%0d exp=0", cyc, issue_cnt);
            end
            advance();
        end
        rstn = 1'b1;
        vld  = '0;
    endtask

    task automatic test_single();
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                vld[2] = 1'b1; a_v[2] = 32'd3; b_v[2] = 32'hFFFF_FFFC; c_v[2] = 32'd5; sub_v[2] = 1'b0;
            end
            apply();
            @(negedge clk);
            eval_cycle();
            n_checks++;
            if (bus.req_ready !== er) begin
                n_err++; $display("FAIL single_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, er);
            end
            n_checks++;
            if (bus.res_valid !== ev || (ev && (bus.res_id !== eid || bus.res_p !== ep))) begin
                n_err++; $display("FAIL single_result cyc=%0d got v=%b id=%0d p=%h exp v=%b id=%0d p=%h", cyc, bus.res_valid, bus.res_id, bus.res_p, ev, eid, ep);
            end
            if (i == 2) begin
                n_checks++;
                if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd2 || bus.res_p !== 32'hFFFF_FFF9 || issue_cnt !== 32'd1) begin
                    n_err++; $display("FAIL single_const got v=%b id=%0d p=%h cnt=%0d exp v=1 id=2 p=fffffff9 cnt=1", bus.res_valid, bus.res_id, bus.res_p, issue_cnt);
                end
            end
            advance();
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] onehot;
        for (int i = 0; i < 15; i++) begin
            rstn = (i != 0);
            for (int j = 0; j < N; j++) if (!vld[j]) begin vld[j] = 1'b1; rand_ops(j); end
            apply();
            @(negedge clk);
            eval_cycle();
            n_checks++;
            if (bus.req_ready !== er) begin
                n_err++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, er);
            end
            n_checks++;
            if (bus.res_valid !== ev || (ev && (bus.res_id !== eid || bus.res_p !== ep))) begin
                n_err++; $display("FAIL rr_result cyc=%0d got v=%b id=%0d p=%h exp v=%b id=%0d p=%h", cyc, bus.res_valid, bus.res_id, bus.res_p, ev, eid, ep);
            end
            n_checks++;
            if (issue_cnt !== ec) begin
                n_err++; $display("FAIL rr_cnt cyc=%0d got=%0d exp=%0d", cyc, issue_cnt, ec);
            end
            if (i > 0) begin
                onehot = 4'b0001 << ((i - 1) % N);
                n_checks++;
                if (bus.req_ready !== onehot) begin
                    n_err++; $display("FAIL rr_order step=%0d got=%b exp=%b", i, bus.req_ready, onehot);
                end
            end
            advance();
        end
        vld = '0;
    endtask

    task automatic test_arith();
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                vld[0] = 1'b1; a_v[0] = 32'h7FFF_FFFF; b_v[0] = 32'd2; c_v[0] = 32'd1; sub_v[0] = 1'b1;
            end else if (i == 1) begin
                vld[0] = 1'b1; a_v[0] = 32'h8000_0000; b_v[0] = 32'h8000_0000; c_v[0] = 32'd0; sub_v[0] = 1'b0;
            end
            apply();
            @(negedge clk);
            eval_cycle();
            n_checks++;
            if (bus.res_valid !== ev || (ev && (bus.res_id !== eid || bus.res_p !== ep))) begin
                n_err++; $display("FAIL arith_result cyc=%0d got v=%b id=%0d p=%h exp v=%b id=%0d p=%h", cyc, bus.res_valid, bus.res_id, bus.res_p, ev, eid, ep);
            end
            if (i >= 2) begin
                n_checks++;
                if (bus.res_valid !== 1'b1 || bus.res_p !== ((i == 2) ? 32'hFFFF_FFFD : 32'h0)) begin
                    n_err++; $display("FAIL arith_const step=%0d got v=%b p=%h", i, bus.res_valid, bus.res_p);
                end
            end
            advance();
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 8; i++) begin
            hold_r = (i >= 1 && i <= 3);
            if (i == 0) begin vld[0] = 1'b1; rand_ops(0); end
            if (i == 1) begin
                vld[1] = 1'b1; rand_ops(1);
                vld[3] = 1'b1; rand_ops(3);
            end
            apply();
            @(negedge clk);
            eval_cycle();
            n_checks++;
            if (bus.req_ready !== er) begin
                n_err++; $display("FAIL hold_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, er);
            end
            n_checks++;
            if (bus.res_valid !== ev || (ev && (bus.res_id !== eid || bus.res_p !== ep))) begin
                n_err++; $display("FAIL hold_result cyc=%0d got v=%b id=%0d p=%h exp v=%b id=%0d p=%h", cyc, bus.res_valid, bus.res_id, bus.res_p, ev, eid, ep);
            end
            if (i >= 1 && i <= 4) begin
                n_checks++;
                if (bus.req_ready !== ((i == 4) ? 4'b0010 : 4'b0000)) begin
                    n_err++; $display("FAIL hold_grant step=%0d got=%b", i, bus.req_ready);
                end
            end
            advance();
        end
        hold_r = 1'b0;
        vld    = '0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) begin
            rstn = (i != 2);
            for (int j = 0; j < N; j++) if (!vld[j]) begin vld[j] = 1'b1; rand_ops(j); end
            apply();
            @(negedge clk);
            eval_cycle();
            n_checks++;
            if (bus.req_ready !== er) begin
                n_err++; $display("FAIL rmid_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, er);
            end
            n_checks++;
            if (bus.res_valid !== ev || (ev && (bus.res_id !== eid || bus.res_p !== ep))) begin
                n_err++; $display("FAIL rmid_result cyc=%0d got v=%b id=%0d p=%h exp v=%b id=%0d p=%h", cyc, bus.res_valid, bus.res_id, bus.res_p, ev, eid, ep);
            end
            if (i >= 2 && i <= 4) begin
                n_checks++;
                if (bus.res_valid !== 1'b0) begin
                    n_err++; $display("FAIL rmid_discard step=%0d got v=%b exp v=0", i, bus.res_valid);
                end
            end
            if (i == 3) begin
                n_checks++;
                if (bus.req_ready !== 4'b0001 || issue_cnt !== 32'd0) begin
                    n_err++; $display("FAIL rmid_restart got rdy=%b cnt=%0d exp rdy=0001 cnt=0", bus.req_ready, issue_cnt);
                end
            end
            advance();
        end
        vld = '0;
    endtask

    task automatic test_sparse();
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                if (!vld[3]) begin vld[3] = 1'b1; rand_ops(3); end
            end else begin
                vld[0] = 1'b1; rand_ops(0);
                vld[3] = 1'b1; rand_ops(3);
            end
            apply();
            @(negedge clk);
            eval_cycle();
            n_checks++;
            if (bus.res_valid !== ev || (ev && (bus.res_id !== eid || bus.res_p !== ep))) begin
                n_err++; $display("FAIL sparse_result cyc=%0d got v=%b id=%0d p=%h exp v=%b id=%0d p=%h", cyc, bus.res_valid, bus.res_id, bus.res_p, ev, eid, ep);
            end
            n_checks++;
            if (bus.req_ready !== ((i < 8) ? 4'b1000 : 4'b0001)) begin
                n_err++; $display("FAIL sparse_grant step=%0d got=%b", i, bus.req_ready);
            end
            advance();
        end
        vld = '0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rstn   = ($urandom_range(0, 49) != 0) || (i >= 295);
            hold_r = ($urandom_range(0, 7) == 0) && (i < 295);
            for (int j = 0; j < N; j++) begin
                if (!vld[j] && $urandom_range(0, 2) == 0 && i < 295) begin
                    vld[j] = 1'b1; rand_ops(j);
                end
            end
            if (i >= 295) vld = '0;
            apply();
            @(negedge clk);
            eval_cycle();
            n_checks++;
            if (bus.req_ready !== er) begin
                n_err++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, er);
            end
            n_checks++;
            if (bus.res_valid !== ev || (ev && (bus.res_id !== eid || bus.res_p !== ep))) begin
                n_err++; $display("FAIL rand_result cyc=%0d got v=%b id=%0d p=%h exp v=%b id=%0d p=%h", cyc, bus.res_valid, bus.res_id, bus.res_p, ev, eid, ep);
            end
            n_checks++;
            if (issue_cnt !== ec) begin
                n_err++; $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", cyc, issue_cnt, ec);
            end
            advance();
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL rand_drain got=%0d pending exp=0", exp_q.size());
        end
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        cyc      = 0;
        m_ptr    = 0;
        m_cnt    = '0;
        pend_g   = -1;
        vld      = '0;
        sub_v    = '0;
        for (int j = 0; j < N; j++) begin a_v[j] = '0; b_v[j] = '0; c_v[j] = '0; end
        rstn = 1'b0;
        apply();
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_arith();
        test_hold();
        test_reset_mid();
        test_sparse();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/muladd_arbiter.md
# muladd_arbiter

Round-robin arbiter that shares one `Mul_Add` multiply-accumulate datapath among `NREQ` requesters. It accepts at most one operand set per cycle and tracks the requester ID alongside the datapath's fixed 2-cycle pipeline. It returns each result tagged with its requester ID. It sits between the SCGRA PE-side issue logic and the shared `Mul_Add` instance.

## Interface
Parameters:
- `DWIDTH`, 32: operand/result width, passed to `Mul_Add`.
- `NREQ`, 4: number of requesters; 2..16.
- `IDW`, 2: ID width; equals clog2(`NREQ`).

Ports:
- `clk` input, 1: single clock; all logic on the rising edge.
- `Resetn` input, 1: synchronous, active-low reset.
- `hold` input, 1: when 1, no grants are issued; in-flight operations still complete.
- `req_valid` input, `NREQ`: per-requester request.
- `req_ready` output, `NREQ`: per-requester grant; one-hot or zero.
- `req_a` input, `NREQ*DWIDTH`: packed multiplicands; requester i uses slice [i*DWIDTH +: DWIDTH].
- `req_b` input, `NREQ*DWIDTH`: packed multipliers.
- `req_c` input, `NREQ*DWIDTH`: packed addends.
- `req_sub` input, `NREQ`: 1 selects a*b−c; 0 selects a*b+c.
- `res_valid` output, 1: result strobe, one cycle per accepted request.
- `res_id` output, `IDW`: requester index of the result.
- `res_p` output, `DWIDTH`: result value; meaningful only while `res_valid`=1.
- `issue_cnt` output, 32: count of accepted requests since reset; wraps.

## Operation
- **Acceptance:** a request from i is accepted in a cycle when `req_valid[i]` and `req_ready[i]` are both 1.
- **Requester contract:** a requester holds `valid` and its operands until accepted.
- **Grant logic:**
  - `req_ready` is combinational from `req_valid`, `hold`, `Resetn` and the priority pointer `rr_ptr`.
  - The grant goes to the first requester with valid set, searching `rr_ptr`, `rr_ptr`+1, … modulo `NREQ`.
- **Pointer update:**
  - On acceptance by requester g, `rr_ptr` becomes (g+1) mod `NREQ`.
  - With no acceptance, `rr_ptr` is unchanged.
  - A requester that keeps valid asserted is therefore served at least once every `NREQ` issue cycles.
- **Blocked grants:** `req_ready` is all-zero while `hold`=1 or `Resetn`=0.
- **Operand mux:**
  - The `Mul_Add` inputs a/b/c/subtract are driven from the granted requester's slices.
  - With no grant, they are driven to zero with subtract=0.
- **Tag pipeline:**
  - Two register stages of {valid, id} run in lockstep with `Mul_Add`.
  - Stage 1 loads {1, g} on acceptance and {0, x} otherwise.
  - Stage 2 loads stage 1.
  - `res_valid`/`res_id` are driven from stage 2; `res_p` is `Mul_Add` p.
- **Arithmetic (as implemented by `Mul_Add`):**
  - Signed a*b, truncated to the low `DWIDTH` bits, then ± c modulo 2^`DWIDTH`.
  - No overflow flag.
- **No back-pressure on results:** the consumer must take `res_valid` every cycle it is asserted.
- **Issue counter:** `issue_cnt` increments by 1 on each acceptance and wraps from 2^32−1 to 0.
- **Reset values:**
  - `rr_ptr`=0.
  - Tag stages valid=0, id=0.
  - Outputs: `res_valid`=0, `res_id`=0, `res_p`=0, `issue_cnt`=0, `req_ready`=0.
- **Reset mid-operation:** in-flight operations are discarded. No `res_valid` is produced for them, including after `Resetn` returns high. `Mul_Add` shares `Resetn`.
- **`hold` asserted with operations in flight:** those operations still produce results on schedule.

## Timing
- **Latency:** a request accepted in cycle t produces `res_valid`=1 with the matching `res_id`/`res_p` in cycle t+2.
- **Throughput:** one request per cycle, sustained indefinitely.
- **Grant response:** `req_ready` responds in the same cycle as `req_valid`; combinational path from `req_valid` to `req_ready`.
- **Pointer timing:** the `rr_ptr` update is visible in the cycle after acceptance.
- **First cycle after `Resetn`→1:** grants are allowed and the search starts at requester 0.
- **`hold` timing:** `hold` rising in cycle t blocks the grant in cycle t itself.

## Structure
- **Shared package `scgra_pkg`:**
  - Constant `MULADD_LAT`=2.
  - Function `clog2` for `IDW`.
  - Typedef for the {valid, id} tag record.
- **Sub-module:** instantiate the existing `Mul_Add` unchanged.
- **Arbiter logic:** the round-robin priority encoder goes in its own sub-module, `rr_arbiter`. Inputs: request vector and pointer. Outputs: one-hot grant and encoded index.
- **Tag pipeline:** depth = `MULADD_LAT`, kept in the top level.

## Test plan
- **Single request:** requester 2 issues a=3, b=−4, c=5, sub=0 in cycle 10 → cycle 12: `res_valid`=1, `res_id`=2, `res_p`=−7; `issue_cnt`=1.
- **Round-robin fairness:** all 4 requesters valid continuously from reset → grant order 0,1,2,3,0,1,…; each result appears exactly 2 cycles after its grant, with the correct id.
- **Subtract and wrap:** a=0x7FFFFFFF, b=2, c=1, sub=1 → `res_p`=0xFFFFFFFD. a=0x80000000, b=0x80000000, c=0, sub=0 → `res_p`=0.
- **`hold`:** assert `hold` for 3 cycles while requesters 1 and 3 are valid → `req_ready`=0 during those cycles. Results already in flight still emerge. `rr_ptr` is unchanged, so requester 1 is granted first after release.
- **Reset mid-operation:** accept two requests, assert `Resetn`=0 the next cycle for 1 cycle → no `res_valid` ever appears for them; `issue_cnt`=0; next grant goes to requester 0.
- **Sparse requests:** only requester 3 is valid → granted every cycle; `rr_ptr` returns to 0 after each grant.
